serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 88 ++++++++
 tb/tb_serial_add_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequencer feeding a Mealy bit-serial adder and collecting its sum
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             sa_a,
    output logic             sa_b,
    output logic             sa_reset,
    input  logic             sa_s
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum_sr;
    logic [WIDTH:0]   sum_next;
    logic             feed;

    // Operands shift right so bit 0 is always the current serial bit; after WIDTH
    // shifts they are zero, which also yields the zero inputs of the flush cycle.
    assign sum_next = {sa_s, sum_sr[WIDTH:1]};
    assign feed     = (state == S_SHIFT) && (cnt != LAST);

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign sa_reset = reset | (state == S_CLR);
    assign sa_a     = feed & a_reg[0];
    assign sa_b     = feed & b_reg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            sum_sr <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        cnt   <= '0;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    sum_sr <= sum_next;
                    if (cnt == LAST) begin
                        result <= sum_next;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed bench for serial_add_ctrl paired with a serial adder model
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [8:0] result;
    logic       sa_a;
    logic       sa_b;
    logic       sa_reset;
    logic       sa_s;
    logic       carry;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .sa_a     (sa_a),
        .sa_b     (sa_b),
        .sa_reset (sa_reset),
        .sa_s     (sa_s)
    );

    // Mealy serial adder
    assign sa_s = sa_a ^ sa_b ^ carry;
    always_ff @(posedge clk) begin
        if (sa_reset) carry <= 1'b0;
        else          carry <= (sa_a & sa_b) | (sa_a & carry) | (sa_b & carry);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 9'h000) begin errors++; $display("FAIL reset_result got %h want 000", result); end
        checks++; if ({sa_a, sa_b} !== 2'b00) begin errors++; $display("FAIL reset_sa_ab got %b want 00", {sa_a, sa_b}); end
        checks++; if (sa_reset !== 1'b1) begin errors++; $display("FAIL reset_sa_reset got %b want 1", sa_reset); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (sa_reset !== 1'b0) begin errors++; $display("FAIL idle_sa_reset got %b want 0", sa_reset); end
        next_cycle();
    endtask

    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, input string tag);
        int  lat;
        logic seen;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        seen  = 1'b0;
        lat   = 1;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin
                next_cycle();
                lat++;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL %s_timeout no done within 20 cycles", tag); end
        checks++; if (lat != 11) begin errors++; $display("FAIL %s_latency got %0d want 11", tag, lat); end
        checks++; if (result !== exp) begin errors++; $display("FAIL %s_result got %h want %h", tag, result, exp); end
        next_cycle();
    endtask

    task automatic test_basic;
        logic [12:1] srv;
        logic [12:1] dv;
        logic [8:0]  astr;
        logic [8:0]  bstr;
        srv = '0; dv = '0; astr = '0; bstr = '0;
        op_a  = 8'h03;
        op_b  = 8'h01;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            srv[k] = sa_reset;
            dv[k]  = done;
            if (k >= 2 && k <= 10) begin
                astr[k-2] = sa_a;
                bstr[k-2] = sa_b;
            end
            if (k == 11) begin
                checks++; if (result !== 9'h004) begin errors++; $display("FAIL basic_result got %h want 004", result); end
            end
            next_cycle();
        end
        checks++; if (srv !== 12'h001) begin errors++; $display("FAIL basic_sa_reset_trace got %h want 001", srv); end
        checks++; if (dv !== 12'h400) begin errors++; $display("FAIL basic_done_trace got %h want 400", dv); end
        checks++; if (astr !== 9'h003) begin errors++; $display("FAIL basic_sa_a_stream got %h want 003", astr); end
        checks++; if (bstr !== 9'h001) begin errors++; $display("FAIL basic_sa_b_stream got %h want 001", bstr); end
    endtask

    task automatic test_carry;
        run_add(8'hFF, 8'h01, 9'h100, "ff_01");
        run_add(8'hFF, 8'hFF, 9'h1FE, "ff_ff");
        run_add(8'h00, 8'h00, 9'h000, "zero");
    endtask

    task automatic test_held_start;
        logic [8:0] exp_res;
        logic [7:0] a;
        logic [7:0] b;
        exp_res = '0;
        start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            a = 8'(i * 37 + 5);
            b = 8'(i * 91 + 200);
            op_a = a;
            op_b = b;
            if (i % 12 == 0) exp_res = {1'b0, a} + {1'b0, b};
            @(negedge clk);
            checks++; if (done !== (i % 12 == 11)) begin errors++; $display("FAIL held_done cycle %0d got %b want %b", i, done, (i % 12 == 11)); end
            checks++; if (busy !== (i % 12 != 0)) begin errors++; $display("FAIL held_busy cycle %0d got %b want %b", i, busy, (i % 12 != 0)); end
            if (i % 12 == 11) begin
                checks++; if (result !== exp_res) begin errors++; $display("FAIL held_result cycle %0d got %h want %h", i, result, exp_res); end
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        int done_hits;
        op_a  = 8'h12;
        op_b  = 8'h34;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (sa_reset !== 1'b1) begin errors++; $display("FAIL abort_sa_reset got %b want 1", sa_reset); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (result !== 9'h000) begin errors++; $display("FAIL abort_result got %h want 000", result); end
        checks++; if (sa_reset !== 1'b0) begin errors++; $display("FAIL abort_sa_reset_low got %b want 0", sa_reset); end
        done_hits = 0;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_hits++;
        end
        checks++; if (done_hits != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", done_hits); end
        next_cycle();
        run_add(8'h55, 8'hAA, 9'h0FF, "after_abort");
    endtask

    task automatic test_busy_ignore;
        op_a  = 8'h20;
        op_b  = 8'h10;
        start = 1'b1;
        next_cycle();
        op_a = 8'hFF;
        op_b = 8'hFF;
        @(negedge clk);
        checks++; if (sa_reset !== 1'b1) begin errors++; $display("FAIL ign_clr_sa_reset got %b want 1", sa_reset); end
        checks++; if (result !== 9'h0FF) begin errors++; $display("FAIL ign_clr_result got %h want 0ff", result); end
        next_cycle();
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            checks++; if (result !== 9'h0FF) begin errors++; $display("FAIL ign_hold_result cycle %0d got %h want 0ff", c, result); end
            checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL ign_shift_flags cycle %0d got %b want 10", c, {busy, done}); end
            next_cycle();
        end
        start = 1'b1;
        op_a  = 8'h77;
        op_b  = 8'h77;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL ign_done_flags got %b want 11", {busy, done}); end
        checks++; if (result !== 9'h030) begin errors++; $display("FAIL ign_result got %h want 030", result); end
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ign_idle_flags got %b want 00", {busy, done}); end
        checks++; if (result !== 9'h030) begin errors++; $display("FAIL ign_idle_result got %h want 030", result); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_reset_start;
        reset = 1'b1;
        start = 1'b1;
        op_a  = 8'h01;
        op_b  = 8'h01;
        next_cycle();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy got %b want 0", busy); end
        checks++; if (sa_reset !== 1'b0) begin errors++; $display("FAIL rs_no_clr got %b want 0", sa_reset); end
        checks++; if (result !== 9'h000) begin errors++; $display("FAIL rs_result got %h want 000", result); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy_later got %b want 0", busy); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_held_start();
        test_reset_mid();
        test_busy_ignore();
        test_reset_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
